// File: rtl/if_id_hazard_ctrl_if.sv
// Signal bundle between the IF/ID sequencing controller and the pipeline.
// The master drives the hazard and fetch inputs. The slave is the controller,
// which returns the stage enables, the FSM state and the statistics.
interface if_id_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [5:0]       id_opcode;
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             idex_mem_read;
   logic [4:0]       idex_rt;
   logic             branch_taken;
   logic             jump;
   logic             imem_ready;

   logic             pc_write;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_bubble;
   logic [1:0]       state;
   logic             imem_timeout;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      output id_opcode, id_rs, id_rt, idex_mem_read, idex_rt,
             branch_taken, jump, imem_ready,
      input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
             state, imem_timeout, stall_cnt, flush_cnt
   );

   modport slave (
      input  id_opcode, id_rs, id_rt, idex_mem_read, idex_rt,
             branch_taken, jump, imem_ready,
      output pc_write, if_id_write, if_id_flush, id_ex_bubble,
             state, imem_timeout, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID and PC sequencing controller: load-use stalls, redirect flush window,
// instruction-memory wait with sticky timeout, and saturating statistics.
//
//   state        | meaning
//   -------------+--------------------------------------------------------
//   ST_RUN       | normal fetch; load-use stalls are single-cycle here
//   ST_REDIRECT  | flushing IF/ID for the remainder of the redirect window
//   ST_IMEM_WAIT | fetch frozen until instruction memory returns data
module if_id_hazard_ctrl #(
   parameter int FLUSH_CYCLES = 1,
   parameter int MAX_WAIT     = 15,
   parameter int CNT_W        = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   if_id_hazard_ctrl_if.slave   ctrl_if
);

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_REDIRECT  = 2'd1,
      ST_IMEM_WAIT = 2'd2
   } state_t;

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam logic [7:0] WAIT_LIMIT   = 8'(MAX_WAIT);

   state_t           state_q, state_d;
   logic [2:0]       flush_rem_q, flush_rem_d;
   logic [7:0]       wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic uses_rt;
   logic load_use;
   logic redirect;
   logic pc_write, if_id_write, if_id_flush, id_ex_bubble;

   assign uses_rt = (ctrl_if.id_opcode == 6'h00) | (ctrl_if.id_opcode == 6'h04) |
                    (ctrl_if.id_opcode == 6'h05) | (ctrl_if.id_opcode == 6'h2B);

   // Register 0 is hard-wired, so a load targeting it never creates a hazard.
   assign load_use = ctrl_if.idex_mem_read & (ctrl_if.idex_rt != 5'd0) &
                     ((ctrl_if.idex_rt == ctrl_if.id_rs) |
                      (uses_rt & (ctrl_if.idex_rt == ctrl_if.id_rt)));

   assign redirect = ctrl_if.branch_taken | ctrl_if.jump;

   // Control outputs and next state; priority is redirect, imem wait, load-use.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      state_d      = state_q;
      flush_rem_d  = flush_rem_q;
      wait_cnt_d   = wait_cnt_q;
      timeout_d    = timeout_q;

      case (state_q)
         ST_RUN, ST_IMEM_WAIT: begin
            if (redirect) begin
               if_id_flush  = 1'b1;
               id_ex_bubble = ctrl_if.branch_taken;
               wait_cnt_d   = 8'd0;
               if (FLUSH_CYCLES > 1) begin
                  state_d     = ST_REDIRECT;
                  flush_rem_d = FLUSH_RELOAD;
               end else begin
                  state_d     = ST_RUN;
               end
            end else if (!ctrl_if.imem_ready) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_bubble = 1'b1;
               state_d      = ST_IMEM_WAIT;
               if (state_q == ST_RUN) begin
                  wait_cnt_d = 8'd1;
               end else if (wait_cnt_q != 8'hFF) begin
                  wait_cnt_d = wait_cnt_q + 8'd1;
               end
               if (wait_cnt_d >= WAIT_LIMIT) begin
                  timeout_d = 1'b1;
               end
            end else begin
               state_d    = ST_RUN;
               wait_cnt_d = 8'd0;
               if (load_use) begin
                  pc_write     = 1'b0;
                  if_id_write  = 1'b0;
                  id_ex_bubble = 1'b1;
               end
            end
         end
         ST_REDIRECT: begin
            pc_write    = ctrl_if.imem_ready;
            if_id_flush = 1'b1;
            if (redirect) begin
               pc_write    = 1'b1;
               flush_rem_d = FLUSH_RELOAD;
            end else if (ctrl_if.imem_ready) begin
               // The window only advances on cycles that actually fetched.
               if (flush_rem_q <= 3'd1) begin
                  flush_rem_d = 3'd0;
                  state_d     = ST_RUN;
               end else begin
                  flush_rem_d = flush_rem_q - 3'd1;
               end
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase

      // Hold the pipeline quiet while reset is asserted.
      if (!rst_n) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end
   end

   // Saturating statistics driven by the final control outputs.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (if_id_flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + 1'b1;
      end
   end

   // State, window/wait counters, sticky timeout and statistics registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_RUN;
         flush_rem_q <= 3'd0;
         wait_cnt_q  <= 8'd0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_rem_q <= flush_rem_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign ctrl_if.pc_write     = pc_write;
   assign ctrl_if.if_id_write  = if_id_write;
   assign ctrl_if.if_id_flush  = if_id_flush;
   assign ctrl_if.id_ex_bubble = id_ex_bubble;
   assign ctrl_if.state        = state_q;
   assign ctrl_if.imem_timeout = timeout_q;
   assign ctrl_if.stall_cnt    = stall_cnt_q;
   assign ctrl_if.flush_cnt    = flush_cnt_q;

endmodule
